uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART peripheral transmitter between NREQ byte producers through the peripheral's bus (cs/rd/wr/addr/data).
//  Round-robin arbiter picks a requester; FSM writes its byte (addr 0x0), starts tx (0x8), polls tx-busy (0x4) rise/fall, then acks.
//  Hung transfers: watchdog, STOP write (0xC), sticky error. Sits between CPU-side producers and the UART peripheral.
// PARAMETERS
//  NREQ     2     number of requesters (1..8)
//  RISE_TO  16    max poll cycles waiting for tx-busy to rise after start
//  FALL_TO  4096  max poll cycles waiting for tx-busy to fall (>= one frame at slowest baud)
// PORTS
//  clk        in   1        system clock; all state updates on posedge
//  rst        in   1        asynchronous, active-high reset
//  req        in   NREQ     level request per producer; held with data stable until ack
//  req_data   in   8*NREQ   byte per producer, slice i = [8i+7:8i]
//  ack        out  NREQ     one-cycle pulse to granted producer on completion
//  grant_id   out  3        index of current/last granted producer
//  busy       out  1        high whenever FSM is not IDLE
//  err        out  1        sticky timeout flag
//  err_clr    in   1        clears err (err_clr wins over a same-cycle set)
//  bus_cs     out  1        peripheral chip select
//  bus_rd     out  1        peripheral read strobe
//  bus_wr     out  1        peripheral write strobe
//  bus_addr   out  4        peripheral register address
//  bus_wdata  out  16       write data; {8'h00, byte} for DATA, 16'h0001 for START/STOP
//  bus_rdata  in   16       peripheral read data; only bit 0 used (tx busy)
// BEHAVIOUR
//  - Reset (async): all outputs 0, bus idle (cs=rd=wr=0, addr=0), state IDLE, rr pointer 0 (req[0] highest), counters 0.
//  - Bus outputs are registered and held one full cycle; the peripheral samples on negedge and updates rdata by the next posedge.
//  - A read issued in cycle N is sampled at the posedge ending cycle N.
//  - FSM states and transitions:
//    - IDLE: if any req -> latch winner index + byte -> WR_DATA.
//    - WR_DATA: cs=1, wr=1, addr=0x0 for 1 cycle -> START.
//    - START: cs=1, wr=1, addr=0x8 for 1 cycle -> WAIT_RISE.
//    - WAIT_RISE: cs=1, rd=1, addr=0x4 each cycle.
//      - rdata[0]=1 -> WAIT_FALL, counter cleared.
//      - counter reaches RISE_TO -> set err -> STOP.
//    - WAIT_FALL: same read.
//      - rdata[0]=0 -> DONE.
//      - counter reaches FALL_TO -> set err -> STOP.
//    - STOP: cs=1, wr=1, addr=0xC for 1 cycle -> DONE.
//    - DONE: bus idle; ack[grant_id]=1 for 1 cycle; rr pointer = grant_id+1 (mod NREQ) -> IDLE.
//  - Minimum latency from req seen in IDLE to ack = 6 cycles (busy rises after 1 poll, falls after 1 poll).
//  - Timed-out bytes are still acked (dropped); producers observe err.
//  - Arbitration is evaluated only in IDLE; req changes while busy have no effect until DONE.
//  - A req deasserted before ack is still served using the byte latched at grant.
//  - rr pointer: search starts at pointer and wraps at NREQ-1 -> 0. A single requester is re-granted back-to-back with 1 IDLE cycle between.
//  - Counters saturate at their limit (width $clog2(FALL_TO+1)); no wrap.
//  - rst mid-transfer: immediate abort, no ack, no STOP write, err cleared.
// STRUCTURE
//  - Shared package uart_pkg:
//    - register address constants UART_A_DATA=4'h0, UART_A_RXD=4'h2, UART_A_TXBUSY=4'h4, UART_A_RXBUSY=4'h6,
//      UART_A_START=4'h8, UART_A_RXGO=4'hA, UART_A_DONE=4'hB, UART_A_STOP=4'hC;
//    - FSM state encoding (7 states, 3 bits).
//  - Sub-module rr_arbiter (NREQ, req, pointer -> one-hot grant + index), combinational, reusable for an RX-side scheduler.
// TESTING
//  - Single req[0]=1, data 8'hA5; model busy high 10 cycles after START -> bus seq (0x0 wr 0x00A5),(0x8 wr),(0x4 rd)x11; ack[0] pulses once; err=0.
//  - req=2'b11 held, data0=8'h11, data1=8'h22 -> grant order 0,1,0,1; bus DATA writes 0x11,0x22,0x11,0x22; each ack 1 cycle.
//  - Model never raises busy -> 16 polls, STOP write to 0xC, err=1, ack still pulses; err_clr=1 -> err=0 next cycle.
//  - Busy stuck high -> FALL_TO polls, STOP write, err=1; with err_clr asserted in the set cycle, err stays 0.
//  - Assert rst during WAIT_FALL -> all outputs 0 without waiting for clk, no ack.
//    After release, req[1] pending is granted first only if rr pointer says so (pointer=0 -> req[1] served when req[0]=0).
//  - req[1] dropped during WAIT_RISE -> transfer completes with latched byte, ack[1] pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler:
// peripheral register map, FSM encoding and per-state bus beats.
package uart_pkg;

    localparam logic [3:0] UART_A_DATA   = 4'h0;
    localparam logic [3:0] UART_A_RXD    = 4'h2;
    localparam logic [3:0] UART_A_TXBUSY = 4'h4;
    localparam logic [3:0] UART_A_RXBUSY = 4'h6;
    localparam logic [3:0] UART_A_START  = 4'h8;
    localparam logic [3:0] UART_A_RXGO   = 4'hA;
    localparam logic [3:0] UART_A_DONE   = 4'hB;
    localparam logic [3:0] UART_A_STOP   = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_START,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_STOP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
    } bus_t;

    // Bus beat presented for the whole cycle spent in state s.
    function automatic bus_t bus_for(state_t s, logic [7:0] b);
        bus_t r;
        r = '0;
        case (s)
            S_WR_DATA: begin
                r.cs = 1'b1; r.wr = 1'b1;
                r.addr = UART_A_DATA; r.wdata = {8'h00, b};
            end
            S_START: begin
                r.cs = 1'b1; r.wr = 1'b1;
                r.addr = UART_A_START; r.wdata = 16'h0001;
            end
            S_WAIT_RISE, S_WAIT_FALL: begin
                r.cs = 1'b1; r.rd = 1'b1;
                r.addr = UART_A_TXBUSY;
            end
            S_STOP: begin
                r.cs = 1'b1; r.wr = 1'b1;
                r.addr = UART_A_STOP; r.wdata = 16'h0001;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; search starts at pointer and wraps.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      pointer,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      index,
    output logic            valid
);

    always_comb begin
        int idx;
        grant = '0;
        index = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(pointer) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                index      = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NREQ byte producers via the
// peripheral register bus, with poll timeouts and a sticky error flag.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int RISE_TO = 16,
    parameter int FALL_TO = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [2:0]        grant_id,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic              bus_cs,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [3:0]        bus_addr,
    output logic [15:0]       bus_wdata,
    input  logic [15:0]       bus_rdata
);

    localparam int CW = $clog2(FALL_TO + 1);
    localparam logic [CW-1:0] RISE_LIM = CW'(RISE_TO - 1);
    localparam logic [CW-1:0] FALL_LIM = CW'(FALL_TO - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [2:0]      ptr, ptr_nx;
    logic [2:0]      gid, gid_nx;
    logic [7:0]      byte_q, byte_nx;
    logic            err_set;
    bus_t            bus_q;
    logic [NREQ-1:0] arb_grant;
    logic [2:0]      arb_idx;
    logic            arb_valid;
    logic            unused_rdata;

    assign unused_rdata = ^bus_rdata[15:1];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .pointer (ptr),
        .grant   (arb_grant),
        .index   (arb_idx),
        .valid   (arb_valid)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        gid_nx   = gid;
        byte_nx  = byte_q;
        err_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    gid_nx = arb_idx;
                    for (int i = 0; i < NREQ; i++)
                        if (arb_grant[i]) byte_nx = req_data[8*i +: 8];
                    state_nx = S_WR_DATA;
                end
            end
            S_WR_DATA: state_nx = S_START;
            S_START: begin
                cnt_nx   = '0;
                state_nx = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (bus_rdata[0]) begin
                    cnt_nx   = '0;
                    state_nx = S_WAIT_FALL;
                end else if (cnt >= RISE_LIM) begin
                    err_set  = 1'b1;
                    state_nx = S_STOP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_WAIT_FALL: begin
                if (!bus_rdata[0]) begin
                    state_nx = S_DONE;
                end else if (cnt >= FALL_LIM) begin
                    err_set  = 1'b1;
                    state_nx = S_STOP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_STOP: state_nx = S_DONE;
            S_DONE: begin
                ptr_nx   = (gid == 3'(NREQ - 1)) ? 3'd0 : gid + 3'd1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ptr    <= '0;
            gid    <= '0;
            byte_q <= '0;
            bus_q  <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ptr    <= ptr_nx;
            gid    <= gid_nx;
            byte_q <= byte_nx;
            // Register the beat of the state being entered so it is stable all cycle.
            bus_q  <= bus_for(state_nx, byte_nx);
            if (err_clr)      err <= 1'b0;
            else if (err_set) err <= 1'b1;
        end
    end

    assign ack       = (state == S_DONE) ? (NREQ'(1) << gid) : '0;
    assign grant_id  = gid;
    assign busy      = (state != S_IDLE);
    assign bus_cs    = bus_q.cs;
    assign bus_rd    = bus_q.rd;
    assign bus_wr    = bus_q.wr;
    assign bus_addr  = bus_q.addr;
    assign bus_wdata = bus_q.wdata;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural
// UART tx-busy model driving bus_rdata.
module tb_uart_tx_scheduler;

    localparam int NREQ    = 2;
    localparam int RISE_TO = 16;
    localparam int FALL_TO = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  ack;
    logic [2:0]  grant_id;
    logic        busy;
    logic        err;
    logic        err_clr = 1'b0;
    logic        bus_cs, bus_rd, bus_wr;
    logic [3:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NREQ(NREQ), .RISE_TO(RISE_TO), .FALL_TO(FALL_TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .grant_id(grant_id), .busy(busy), .err(err),
        .err_clr(err_clr), .bus_cs(bus_cs), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    // Peripheral model: START loads busy_len cycles of busy, each poll consumes one.
    int busy_len = 10;
    bit stuck = 1'b0;
    int busy_left;

    always @(posedge clk or posedge rst) begin
        if (rst) busy_left <= 0;
        else if (bus_cs && bus_wr && bus_addr == 4'h8) busy_left <= busy_len;
        else if (bus_cs && bus_rd && busy_left != 0) busy_left <= busy_left - 1;
    end

    assign bus_rdata = {15'b0, (stuck || busy_left != 0)};

    typedef struct {
        int          kind;
        logic [3:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin : monitor
        ev_t e;
        ev_t got;
        bit  have;
        have = 1'b0;
        if (!rst) begin
            if (bus_cs && bus_wr) begin
                got = '{0, bus_addr, bus_wdata}; have = 1'b1;
            end else if (bus_cs && bus_rd) begin
                got = '{1, bus_addr, 16'h0000}; have = 1'b1;
            end else if (ack != 0) begin
                got = '{2, 4'h0, {11'b0, grant_id, ack}}; have = 1'b1;
            end
            if (have) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event kind=%0d addr=%h data=%h",
                             got.kind, got.addr, got.data);
                end else begin
                    e = q.pop_front();
                    if (e.kind != got.kind || e.addr !== got.addr || e.data !== got.data) begin
                        n_bad++;
                        $display("FAIL bus_event got kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h",
                                 got.kind, got.addr, got.data, e.kind, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic push(input int kind, input logic [3:0] addr, input logic [15:0] data);
        ev_t e;
        e = '{kind, addr, data};
        q.push_back(e);
    endtask

    task automatic xfer_exp(input logic [2:0] id, input logic [7:0] b,
                            input int nreads, input bit stop);
        logic [1:0] oh;
        oh = 2'b01 << id;
        push(0, 4'h0, {8'h00, b});
        push(0, 4'h8, 16'h0001);
        for (int i = 0; i < nreads; i++) push(1, 4'h4, 16'h0000);
        if (stop) push(0, 4'hC, 16'h0001);
        push(2, 4'h0, {11'b0, id, oh});
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic wait_q(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (q.size() > n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        n_cmp++;
        if (q.size() > n) begin
            n_bad++;
            $display("FAIL %s timeout pending=%0d want=%0d", nm, q.size(), n);
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        err_clr = 1'b0;
        stuck = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        check("reset_bus", {bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata}, 32'h0);
        check("reset_ctl", {ack, grant_id, busy, err}, 32'h0);

        // Single requester, busy high for 10 cycles
        busy_len = 10;
        xfer_exp(3'd0, 8'hA5, 11, 1'b0);
        req_data[7:0] = 8'hA5;
        req = 2'b01;
        wait_q(0, 100, "single_xfer");
        req = 2'b00;
        check("single_err", err, 0);
        repeat (4) @(negedge clk);
        #1 check("single_idle", busy, 0);

        // Two held requesters alternate
        do_reset();
        busy_len = 2;
        for (int i = 0; i < 4; i++)
            xfer_exp(3'(i % 2), (i % 2) ? 8'h22 : 8'h11, 3, 1'b0);
        req_data = 16'h2211;
        req = 2'b11;
        wait_q(0, 200, "rr_xfer");
        req = 2'b00;

        // Busy never rises
        do_reset();
        busy_len = 0;
        xfer_exp(3'd0, 8'h3C, RISE_TO, 1'b1);
        req_data = 16'h003C;
        req = 2'b01;
        wait_q(0, 100, "rise_to_xfer");
        req = 2'b00;
        check("rise_to_err", err, 1);
        err_clr = 1'b1;
        @(negedge clk); #1;
        err_clr = 1'b0;
        check("err_clr", err, 0);

        // Busy stuck high, err_clr coincident with the set
        do_reset();
        stuck = 1'b1;
        xfer_exp(3'd0, 8'h77, 1 + FALL_TO, 1'b1);
        req_data = 16'h0077;
        req = 2'b01;
        wait_q(2, FALL_TO + 100, "fall_to_last_poll");
        err_clr = 1'b1;
        @(negedge clk); #1;
        err_clr = 1'b0;
        check("fall_to_clr_wins", err, 0);
        wait_q(0, 20, "fall_to_clr_xfer");
        req = 2'b00;
        check("fall_to_clr_err", err, 0);

        // Busy stuck high without clear
        do_reset();
        stuck = 1'b1;
        xfer_exp(3'd0, 8'h78, 1 + FALL_TO, 1'b1);
        req_data = 16'h0078;
        req = 2'b01;
        wait_q(0, FALL_TO + 100, "fall_to_xfer");
        req = 2'b00;
        check("fall_to_err", err, 1);

        // Reset during WAIT_FALL aborts at once
        do_reset();
        busy_len = 10;
        push(0, 4'h0, 16'h0033);
        push(0, 4'h8, 16'h0001);
        for (int i = 0; i < 3; i++) push(1, 4'h4, 16'h0000);
        req_data = 16'h0033;
        req = 2'b01;
        wait_q(0, 50, "abort_prefix");
        #2 rst = 1'b1;
        #1;
        check("abort_bus", {bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata}, 32'h0);
        check("abort_ctl", {ack, grant_id, busy, err}, 32'h0);
        req = 2'b10;
        req_data = 16'h4400;
        busy_len = 2;
        @(negedge clk);
        xfer_exp(3'd1, 8'h44, 3, 1'b0);
        rst = 1'b0;
        wait_q(0, 100, "after_abort_xfer");
        req = 2'b00;

        // req[1] dropped while waiting for busy to rise
        do_reset();
        busy_len = 3;
        xfer_exp(3'd1, 8'h5A, 4, 1'b0);
        req_data = 16'h5A00;
        req = 2'b10;
        wait_q(5, 50, "drop_first_poll");
        req = 2'b00;
        req_data = 16'h0000;
        wait_q(0, 50, "drop_xfer");
        repeat (10) @(negedge clk);
        #1 check("drop_idle", {busy, err}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
